// File: rtl/mod_count_pkg.sv
// Shared types and constants for the modulus counter sequencer.
package mod_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int unsigned MIN_MOD = 2;

endpackage

// File: rtl/mod_count_core.sv
// WIDTH-bit count register with zero/hold/increment controls and a
// terminal-count compare against the supplied modulus.
module mod_count_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             zero_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] mod_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             term_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Zero takes precedence over increment; neither asserted means hold.
  always_comb begin
    cnt_d = cnt_q;
    if (zero_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == (mod_i - WIDTH'(1)));

endmodule

// File: rtl/mod_count_ctrl.sv
// Start/stop/pause sequencer over mod_count_core: latches the modulus and
// reload mode at start, and reports terminal count and run status.
module mod_count_ctrl
  import mod_count_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] MinMod = WIDTH'(MIN_MOD);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             cnt_zero, cnt_inc, at_term;

  mod_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .clr    (clr),
    .zero_i (cnt_zero),
    .inc_i  (cnt_inc),
    .mod_i  (mod_q),
    .cnt_o  (q),
    .term_o (at_term)
  );

  // Priority stop > start > pause; a rejected start freezes everything for that edge.
  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    mode_d   = mode_q;
    err_d    = 1'b0;
    cnt_zero = 1'b0;
    cnt_inc  = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      cnt_zero = 1'b1;
    end else if (start) begin
      if (mod_val < MinMod) begin
        err_d = 1'b1;
      end else begin
        mod_d    = mod_val;
        mode_d   = auto_reload;
        state_d  = RUN;
        cnt_zero = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (!at_term) begin
            cnt_inc = 1'b1;
          end else begin
            cnt_zero = 1'b1;
            if (!mode_q) state_d = DONE;
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        DONE: begin
          cnt_zero = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mod_q   <= WIDTH'(DEFAULT_MOD);
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign tc   = (state_q == RUN) && at_term;
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_mod_count_ctrl.sv
// Scoreboard bench for mod_count_ctrl: a behavioural model pushes expected
// outputs after each clock edge; a negedge monitor pops and compares them.
module tb_mod_count_ctrl;

  localparam int W = 4;
  localparam int DEF_MOD = 10;

  typedef struct {
    int q;
    int tc;
    int busy;
    int done;
    int err;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr;
  logic         start, stop, pause, auto_reload;
  logic [W-1:0] mod_val;
  logic [W-1:0] dq;
  logic         dtc, dbusy, ddone, derr;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  // Reference model state: 0 idle, 1 run, 2 pause, 3 done.
  int m_st, m_q, m_mod, m_mode, m_err;

  mod_count_ctrl #(
    .WIDTH       (W),
    .DEFAULT_MOD (DEF_MOD)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .mod_val     (mod_val),
    .auto_reload (auto_reload),
    .q           (dq),
    .tc          (dtc),
    .busy        (dbusy),
    .done        (ddone),
    .err         (derr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_q = 0; m_mod = DEF_MOD; m_mode = 0; m_err = 0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.q    = m_q;
    e.tc   = (m_st == 1 && m_q == m_mod - 1) ? 1 : 0;
    e.busy = (m_st == 1 || m_st == 2) ? 1 : 0;
    e.done = (m_st == 3) ? 1 : 0;
    e.err  = m_err;
    return e;
  endfunction

  task automatic model_edge();
    m_err = 0;
    if (stop) begin
      m_st = 0; m_q = 0;
    end else if (start) begin
      if (int'(mod_val) < 2) begin
        m_err = 1;
      end else begin
        m_mod = int'(mod_val); m_mode = int'(auto_reload); m_st = 1; m_q = 0;
      end
    end else if (m_st == 1) begin
      if (pause) m_st = 2;
      else if (m_q == m_mod - 1) begin
        m_q = 0;
        if (m_mode == 0) m_st = 3;
      end else m_q = m_q + 1;
    end else if (m_st == 2) begin
      if (!pause) m_st = 1;
    end else if (m_st == 3) begin
      m_q = 0;
    end
  endtask

  // Apply inputs for one edge, then record the expected post-edge outputs.
  task automatic cyc(input logic s, input logic p, input logic pa, input int m, input logic ar);
    start = s; stop = p; pause = pa; mod_val = W'(m); auto_reload = ar;
    @(posedge clk);
    model_edge();
    sb.push_back(model_outputs());
    #2;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("q",    int'(dq),    e.q);
      chk("tc",   int'(dtc),   e.tc);
      chk("busy", int'(dbusy), e.busy);
      chk("done", int'(ddone), e.done);
      chk("err",  int'(derr),  e.err);
    end
  end

  // Async clear asserted and released between edges.
  task automatic mid_clr();
    chk("q_before_clr", int'(dq), m_q);
    clr = 1'b1;
    #1;
    chk("clr_q_async",    int'(dq),    0);
    chk("clr_busy_async", int'(dbusy), 0);
    chk("clr_tc_async",   int'(dtc),   0);
    sb.delete();
    model_reset();
    sb.push_back(model_outputs());
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; start = 0; stop = 0; pause = 0; mod_val = '0; auto_reload = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    clr = 1'b0;

    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);            // rejected start
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);            // also rejected
    cyc(0, 0, 0, 0, 0);

    cyc(1, 0, 0, 5, 0);            // one-shot M=5
    repeat (15) cyc(0, 0, 0, 0, 0);

    cyc(1, 0, 0, 3, 1);            // auto-reload M=3
    repeat (12) cyc(0, 0, 0, 0, 0);

    cyc(1, 0, 0, 6, 0);            // pause at q=2
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);

    cyc(1, 0, 0, 4, 1);            // pause while at terminal count
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    cyc(1, 0, 0, 6, 0);            // stop beats start
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 6, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    cyc(1, 0, 0, 6, 1);            // restart with new modulus
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 4, 1);
    repeat (6) cyc(0, 0, 0, 0, 0);

    cyc(1, 0, 1, 5, 1);            // start beats pause
    cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    cyc(1, 0, 0, 15, 1);           // full-range modulus
    repeat (20) cyc(0, 0, 0, 0, 0);
    mid_clr();
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_count_ctrl.md
Name: mod_count_ctrl

Overview:
- Synchronous sequencer for a WIDTH-bit up-counter datapath.
- Provides start, stop and pause control, a programmable modulus latched at start, and one-shot or auto-reload modes.
- Outputs a terminal-count indication and status.
- Sits above the counter chain: the system controller uses it to generate divide-by-N ticks and timed windows without hand-wiring clears.

Parameters:
- WIDTH, 4, counter and modulus width in bits.
- DEFAULT_MOD, 10, modulus held after reset until the first accepted start; must satisfy 2 <= DEFAULT_MOD <= 2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- clr  input  1  asynchronous, active-high reset; asserting it immediately forces every register to its reset value.
- start  input  1  level-sampled; accepts a run request and latches mod_val.
- stop  input  1  level-sampled; abort to IDLE.
- pause  input  1  level; hold the count while high (RUN or PAUSE only).
- mod_val  input  WIDTH  requested modulus M; the count runs 0..M-1.
- auto_reload  input  1  sampled with start; 1 = free-run, 0 = one-shot.
- q  output  WIDTH  current count value.
- tc  output  1  high during the cycle q == M-1 while in RUN.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high in DONE, i.e. after a one-shot completes.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (clr=1, async): state=IDLE, q=0, tc=0, busy=0, done=0, err=0, latched M=DEFAULT_MOD, latched mode=one-shot. All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority at each edge: stop > start > pause.
- stop=1 in any state:
  - next state IDLE, q=0.
  - the latched M is kept.
- start=1 (stop=0) in any state, including RUN or PAUSE (restart):
  - if mod_val < 2: start is rejected; err=1 for the next cycle only; state, q, M and mode are unchanged.
  - otherwise: latch M=mod_val and mode=auto_reload; next state RUN, q=0, done=0.
- RUN, no start/stop:
  - pause=1: next state PAUSE, q holds.
  - else if q != M-1: q <= q+1.
  - else (wrap): q <= 0. If auto_reload is latched, stay in RUN; otherwise go to DONE.
- PAUSE: q holds; pause=0 returns to RUN, and counting resumes on the following edge.
- DONE: q=0, done=1; holds until start or stop.
- Latency: start accepted at edge k gives q=0 after k; q=1 after k+1; tc high in the cycle after edge k+M-1. For one-shot, DONE is entered at edge k+M.
- tc:
  - Never asserted in PAUSE, even if q == M-1.
  - Re-asserts when RUN resumes at q == M-1.
- Arithmetic: increment is modulo 2**WIDTH, but q never exceeds M-1 because M <= 2**WIDTH-1. M = 2**WIDTH-1 is legal and gives the full range minus the all-ones value.
- Simultaneous start and pause: start wins; state RUN, q=0. pause is sampled again on the next edge.
- clr mid-run: immediate return to the reset values. Latched M reverts to DEFAULT_MOD and mode to one-shot.

Decomposition:
- Shared package mod_count_pkg holds:
  - state enum: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11
  - constant MIN_MOD=2
- One sub-module, mod_count_core: WIDTH-bit register with synchronous zero, hold and increment controls, async clr, and a terminal-compare output against M-1.
- The FSM, latches and status registers live in mod_count_ctrl.

Test Plan:
- Reset: clr=1 mid-stream, then released -> q=0, tc=busy=done=err=0, state IDLE. Then start with mod_val=0 -> err pulses one cycle, and nothing else changes.
- One-shot M=5: start pulse with auto_reload=0 -> q sequence 0,1,2,3,4; tc high only when q=4; next cycle done=1, busy=0, q=0; held for 10 cycles.
- Auto-reload M=3: start, then run 12 cycles -> q sequence 0,1,2,0,1,2,..., tc pulses every 3rd cycle, done stays 0.
- Pause: M=6, pause at q=2 for 4 cycles -> q holds at 2, busy=1, tc=0. After release, q sequence 3,4,5; tc at q=5.
- Priority and restart: at q=3 with M=6, drive start=1, stop=1 -> IDLE, q=0. Then start with mod_val=4 while RUN is at q=2 -> q=0 next cycle, and wrap now occurs at q=3.
- Boundary: M=15 (WIDTH=4) auto-reload -> q sequence 0..14 then wraps to 0, never reaching 15. Then clr asserted for a partial cycle mid-count -> q=0 immediately, without waiting for a clock edge.
